// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, funct codes,
// FSM state encodings and datapath select / ALU operation codes.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FUNCT_JR = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_I_EXEC   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JAL_ST   = 4'd12
    } state_t;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b100;
    localparam logic [2:0] ALU_OR    = 3'b101;
    localparam logic [2:0] ALU_SLT   = 3'b110;

    localparam logic [1:0] ALUB_B     = 2'b00;
    localparam logic [1:0] ALUB_FOUR  = 2'b01;
    localparam logic [1:0] ALUB_IMM   = 2'b10;
    localparam logic [1:0] ALUB_IMMSH = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_REG_A  = 2'b11;

    localparam logic [1:0] RDST_RT = 2'b00;
    localparam logic [1:0] RDST_RD = 2'b01;
    localparam logic [1:0] RDST_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl_perf_counters.sv
// Cycle and retired-instruction counters for the multicycle controller.
// Instantiated by the top only when MIPS_CTRL_PERF_CNT_EN is defined.
module mips_perf_counters (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_tick,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
);

    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] instr_cnt_q, instr_cnt_d;

    // Next counter values; both wrap naturally modulo 2^32.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q + 32'd1;
        if (instr_tick) begin
            instr_cnt_d = instr_cnt_q + 32'd1;
        end else begin
            instr_cnt_d = instr_cnt_q;
        end
    end

    // Counter registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_q <= 32'd0;
            instr_cnt_q <= 32'd0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore controller FSM sequencing the shared multicycle MIPS datapath.
// Define MIPS_CTRL_PERF_CNT_EN to add the cycle / retired-instruction counters.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0,
    parameter logic [4:0] JAL_REG     = 5'd31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_op,
    output logic [1:0]  pc_source,
    output logic        illegal_op,
    output logic [3:0]  state,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
);

    state_t state_q, state_d;
    logic   pc_write_s, pc_write_cond_s, is_bne_s, instr_tick_s;

    // The link register index is consumed by the datapath; reg_dst=10 selects it.
    if (JAL_REG == 5'd0) begin : g_jal_reg_zero
    end

    // Next-state and Moore output decode; rst forces every output low.
    always_comb begin
        state_d         = state_q;
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        is_bne_s        = (opcode == OP_BNE);
        pc_en           = 1'b0;
        i_or_d          = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        ir_write        = 1'b0;
        reg_dst         = RDST_RT;
        mem_to_reg      = M2R_ALUOUT;
        reg_write       = 1'b0;
        alu_src_a       = 1'b0;
        alu_src_b       = ALUB_B;
        alu_op          = ALU_ADD;
        pc_source       = PCS_ALU;
        illegal_op      = 1'b0;
        if (rst) begin
            state_d = state_t'(RESET_STATE);
        end else begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = ALUB_FOUR;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write_s = 1'b1;
                        state_d    = S_DECODE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
                S_DECODE: begin
                    alu_src_b = ALUB_IMMSH;
                    case (opcode)
                        OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                        OP_RTYPE:       state_d = S_R_EXEC;
                        OP_BEQ, OP_BNE: state_d = S_BRANCH;
                        OP_J:           state_d = S_JUMP;
                        OP_JAL:         state_d = S_JAL_ST;
                        OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI, OP_SLTIU:
                                        state_d = S_I_EXEC;
                        default: begin
                            state_d    = S_FETCH;
                            illegal_op = 1'b1;
                        end
                    endcase
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ALUB_IMM;
                    if (opcode == OP_SW) begin
                        state_d = S_MEM_WR;
                    end else begin
                        state_d = S_MEM_RD;
                    end
                end
                S_MEM_RD: begin
                    i_or_d   = 1'b1;
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        state_d = S_MEM_WB;
                    end else begin
                        state_d = S_MEM_RD;
                    end
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = M2R_MDR;
                    state_d    = S_FETCH;
                end
                S_MEM_WR: begin
                    i_or_d    = 1'b1;
                    mem_write = 1'b1;
                    if (mem_ready) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_MEM_WR;
                    end
                end
                S_R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_FUNCT;
                    if (funct == FUNCT_JR) begin
                        pc_write_s = 1'b1;
                        pc_source  = PCS_REG_A;
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_R_WB;
                    end
                end
                S_R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = RDST_RD;
                    state_d   = S_FETCH;
                end
                S_I_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ALUB_IMM;
                    case (opcode)
                        OP_ANDI:            alu_op = ALU_AND;
                        OP_ORI:             alu_op = ALU_OR;
                        OP_SLTI, OP_SLTIU:  alu_op = ALU_SLT;
                        default:            alu_op = ALU_ADD;
                    endcase
                    state_d = S_I_WB;
                end
                S_I_WB: begin
                    reg_write = 1'b1;
                    state_d   = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a       = 1'b1;
                    alu_op          = ALU_SUB;
                    pc_write_cond_s = 1'b1;
                    pc_source       = PCS_ALUOUT;
                    state_d         = S_FETCH;
                end
                S_JUMP: begin
                    pc_write_s = 1'b1;
                    pc_source  = PCS_JUMP;
                    state_d    = S_FETCH;
                end
                S_JAL_ST: begin
                    pc_write_s = 1'b1;
                    pc_source  = PCS_JUMP;
                    reg_write  = 1'b1;
                    reg_dst    = RDST_RA;
                    mem_to_reg = M2R_PC;
                    state_d    = S_FETCH;
                end
                default: begin
                    state_d    = S_FETCH;
                    illegal_op = 1'b1;
                end
            endcase
            pc_en = pc_write_s | (pc_write_cond_s & (zero ^ is_bne_s));
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= state_t'(RESET_STATE);
        end else begin
            state_q <= state_d;
        end
    end

    assign state = rst ? 4'd0 : state_q;

    // An instruction retires when control falls back into FETCH, unless it was illegal.
    assign instr_tick_s = !rst && (state_q != S_FETCH) && (state_d == S_FETCH) && !illegal_op;

`ifdef MIPS_CTRL_PERF_CNT_EN
    mips_perf_counters u_perf (
        .clk        (clk),
        .rst        (rst),
        .instr_tick (instr_tick_s),
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
    );
`else
    logic unused_tick_s;
    assign unused_tick_s = instr_tick_s;
    assign cycle_cnt     = 32'd0;
    assign instr_cnt     = 32'd0;
`endif

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore-style controller FSM that sequences the shared multicycle MIPS datapath: one memory, one ALU, IR/MDR/A/B/ALUOut registers.
- Issues per-state mux selects, register enables and ALU op codes.
- Stalls on a memory ready handshake.
- Sits between the instruction register and the datapath in mips_core; replaces single-cycle decode.

Parameters:
- RESET_STATE, 4'd0, state entered on reset (FETCH).
- JAL_REG, 5'd31, link register index; informational, used by the datapath reg_dst=10 path.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26]; stable from DECODE until return to FETCH
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, valid in BRANCH state
- mem_ready  in  1  memory completes the access this cycle
- pc_en  out  1  PC load = pc_write | (pc_write_cond & (zero ^ is_bne))
- i_or_d  out  1  0 = PC address, 1 = ALUOut address
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load
- reg_dst  out  2  00 rt, 01 rd, 10 $31
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC
- reg_write  out  1  register file write
- alu_src_a  out  1  0 PC, 1 A
- alu_src_b  out  2  00 B, 01 const 4, 10 signext imm, 11 signext imm<<2
- alu_op  out  3  000 add, 001 sub, 010 use funct, 100 and, 101 or, 110 slt
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 A (JR)
- illegal_op  out  1  one-cycle pulse on unsupported opcode
- state  out  4  current state, for debug
- cycle_cnt  out  32  cycle counter (optional feature)
- instr_cnt  out  32  retired-instruction counter (optional feature)

Behaviour:
- State register updates on clk. rst=1 on a clock edge: state <= FETCH. Any in-flight instruction is abandoned; no pc_en, reg_write or mem_write is generated during the rst cycle.
- While rst is high, all outputs are forced to 0 and state reads 0.
- Outputs are combinational from state, plus opcode/funct/zero where noted. No output depends on mem_ready except the stall.

States and transitions:
- FETCH: mem_read, ir_write, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00, pc_write.
  - mem_ready=0: hold; suppress ir_write and pc_write.
  - mem_ready=1: DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=000 (branch target into ALUOut). Next state by opcode:
  - LW/SW -> MEM_ADDR
  - R-type -> R_EXEC
  - BEQ/BNE -> BRANCH
  - J -> JUMP
  - JAL -> JAL_ST
  - ADDI/ADDIU/ANDI/ORI/SLTI/SLTIU -> I_EXEC
  - other -> FETCH, with illegal_op pulsed; instruction treated as NOP.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000. LW -> MEM_RD; SW -> MEM_WR.
- MEM_RD: i_or_d=1, mem_read. Hold until mem_ready, then MEM_WB.
- MEM_WB: reg_write, reg_dst=00, mem_to_reg=01 -> FETCH.
- MEM_WR: i_or_d=1, mem_write. Hold until mem_ready, then FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=010.
  - funct=001000 (JR): pc_write, pc_source=11 -> FETCH.
  - else -> R_WB.
- R_WB: reg_write, reg_dst=01, mem_to_reg=00 -> FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10; alu_op = 000 for ADDI/ADDIU, 100 for ANDI, 101 for ORI, 110 for SLTI/SLTIU -> I_WB.
- I_WB: reg_write, reg_dst=00, mem_to_reg=00 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond, pc_source=01. is_bne=(opcode==000101) -> FETCH.
- JUMP: pc_write, pc_source=10 -> FETCH.
- JAL_ST: pc_write, pc_source=10, reg_write, reg_dst=10, mem_to_reg=10 -> FETCH. PC already holds PC+4.

Latency without wait states:
- BEQ/BNE/J/JAL/JR: 3 cycles
- R-type/I-type/SW: 4 cycles
- LW: 5 cycles
- Each mem_ready=0 cycle adds one cycle.

Other rules:
- Unused state encodings -> FETCH next cycle, with illegal_op pulsed.
- mem_read and mem_write are never both 1.
- reg_write and mem_write are never both 1.

Optional Feature:
- Macro: MIPS_CTRL_PERF_CNT_EN.
- Defined:
  - cycle_cnt increments every non-reset cycle.
  - instr_cnt increments on every transition into FETCH from a non-FETCH state, excluding illegal opcodes.
  - Both clear on rst and wrap modulo 2^32.
- Undefined: both outputs tied to 0 and no counter flops are synthesized.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode and funct localparams
  - state encodings (4-bit)
  - alu_op codes
  - alu_src_b, pc_source, reg_dst and mem_to_reg select codes
- Sub-module mips_perf_counters holds the two counters; instantiated only under the macro.
- Next-state and output decode stay in the top module.

Test Plan:
- rst held 3 cycles mid-LW (in MEM_RD), then released, with mem_ready=1: all outputs 0 during rst; state=FETCH the cycle after release; no reg_write is seen for the aborted LW.
- R-type add (opcode 000000, funct 100000), mem_ready=1: state sequence FETCH, DECODE, R_EXEC, R_WB; reg_write=1, reg_dst=01 in R_WB; 4 cycles.
- LW with mem_ready=0 for 2 cycles in FETCH and 3 cycles in MEM_RD: total 10 cycles; ir_write=0 while stalled; mem_to_reg=01, reg_write=1 in MEM_WB.
- BEQ with zero=1 -> pc_en=1 in BRANCH. BEQ with zero=0 -> pc_en=0. BNE with zero=0 -> pc_en=1. pc_source=01 in all three cases.
- JAL: pc_en=1, pc_source=10, reg_dst=10, mem_to_reg=10, reg_write=1 in cycle 3. JR (funct 001000): pc_source=11 in R_EXEC, no R_WB state.
- Opcode 111111: illegal_op pulses 1 cycle, return to FETCH, no writes. With MIPS_CTRL_PERF_CNT_EN, instr_cnt is unchanged while cycle_cnt advances by 2.
